// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: command encoding,
// FSM state type and default widths.
package hilo_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    // Codes 000..011 are the iterative ops; MSB set means MT or reserved.
    function automatic logic is_muldiv(input logic [2:0] code);
        return code[2] == 1'b0;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: right-shifting shift-add multiply
// ({partial, multiplier}) or left-shifting restoring divide ({rem, quotient}).
module muldiv_step #(
    parameter int WIDTH = hilo_pkg::WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
        // Shifted remainder is one bit wider than the divisor; a borrow means restore.
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        if (is_div) begin
            if (trial[WIDTH]) begin
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO owner: immediate MTHI/MTLO, iterative MULT/MULTU/DIV/DIVU with a
// final sign fix-up, and a pipeline stall while an operation is in flight.
//
//   state | meaning
//   IDLE  | accepts commands; MT ops write HI/LO directly
//   CALC  | WIDTH unsigned iterations on magnitudes
//   FIXUP | apply signs, write HI/LO, pulse done
module hilo_muldiv_seq #(
    parameter int WIDTH = hilo_pkg::WIDTH,
    parameter int CNT_W = hilo_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    import hilo_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               last_iter;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .opnd    (opnd),
        .is_div  (is_div),
        .acc_nxt (acc_step)
    );

    assign busy      = (state != IDLE);
    assign stall     = busy & (op_valid | mf_req);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        op_signed = ~op[0];
        a_neg     = op_signed & rs_val[WIDTH-1];
        b_neg     = op_signed & rt_val[WIDTH-1];
        a_mag     = a_neg ? -rs_val : rs_val;
        b_mag     = b_neg ? -rt_val : rt_val;
    end

    // Divide by zero bypasses the quotient sign so LO is all-ones for DIV too;
    // the remainder path already yields the original dividend.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        fix_hi   = acc[2*WIDTH-1:WIDTH];
        fix_lo   = acc[WIDTH-1:0];
        if (!is_div) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else begin
            if (neg_rem) begin
                fix_hi = -acc[2*WIDTH-1:WIDTH];
            end
            if (div_zero) begin
                fix_lo = '1;
            end else if (neg_res) begin
                fix_lo = -acc[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_valid && is_muldiv(op)) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == FIXUP);
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end else if (is_muldiv(op)) begin
                            is_div   <= op[1];
                            neg_res  <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            div_zero <= (rt_val == '0);
                            cnt      <= '0;
                            // Multiply keeps the multiplier in the low half; divide
                            // keeps the dividend there as the quotient seed.
                            if (op[1]) begin
                                acc  <= {{WIDTH{1'b0}}, a_mag};
                                opnd <= b_mag;
                            end else begin
                                acc  <= {{WIDTH{1'b0}}, b_mag};
                                opnd <= a_mag;
                            end
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIXUP: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Self-checking bench for hilo_muldiv_seq: fixed vector table, hand-written
// stall/reset sequences, and random ops against an arithmetic reference.
module tb_hilo_muldiv_seq;

    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int checks = 0;
    int errors = 0;

    hilo_muldiv_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mf_req   (mf_req),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference result computed with plain 64-bit arithmetic.
    task automatic ref_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rhi, output logic [31:0] rlo);
        logic signed [63:0] sa, sb, p, q, r;
        logic [63:0] up;
        sa = 64'(signed'(a));
        sb = 64'(signed'(b));
        rhi = '0;
        rlo = '0;
        case (c)
            OP_MULT: begin
                p = sa * sb;
                rhi = p[63:32];
                rlo = p[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                rhi = up[63:32];
                rlo = up[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin
                    rhi = a;
                    rlo = '1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    rhi = r[31:0];
                    rlo = q[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    rhi = a;
                    rlo = '1;
                end else begin
                    rhi = a % b;
                    rlo = a / b;
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name);
        int n;
        int nbusy;
        @(negedge clk);
        op_valid = 1'b1;
        op       = c;
        rs_val   = a;
        rt_val   = b;
        #1;
        chk({name, " stall_at_issue"}, 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        n = 1;
        nbusy = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) nbusy++;
        end
        chk({name, " done"}, 64'(done), 64'd1);
        chk({name, " latency"}, 64'(n), 64'd34);
        chk({name, " busy_cycles"}, 64'(nbusy), 64'd33);
        chk({name, " hi"}, 64'(hi), 64'(ehi));
        chk({name, " lo"}, 64'(lo), 64'(elo));
        @(posedge clk);
        #1;
        chk({name, " done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] rh, rl, ra, rb;
        logic [2:0]  rc;
        int n;

        reset_n  = 1'b0;
        op_valid = 1'b0;
        op       = 3'd0;
        rs_val   = '0;
        rt_val   = '0;
        mf_req   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        reset_n = 1'b1;

        // MTHI while idle.
        @(negedge clk);
        op_valid = 1'b1; op = OP_MTHI; rs_val = 32'h1234_5678;
        #1;
        chk("mthi stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("mthi hi", 64'(hi), 64'h1234_5678);
        chk("mthi done", 64'(done), 64'd0);
        chk("mthi busy", 64'(busy), 64'd0);

        // Reserved op is ignored.
        @(negedge clk);
        op_valid = 1'b1; op = 3'b110; rs_val = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("resv hi", 64'(hi), 64'h1234_5678);
        chk("resv lo", 64'(lo), 64'd0);
        chk("resv busy", 64'(busy), 64'd0);

        // MTLO together with MF while idle: no stall.
        @(negedge clk);
        op_valid = 1'b1; op = OP_MTLO; rs_val = 32'h0000_00A5; mf_req = 1'b1;
        #1;
        chk("mtlo+mf stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; mf_req = 1'b0;
        chk("mtlo lo", 64'(lo), 64'h0000_00A5);

        vq.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"});
        vq.push_back('{OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m7x3"});
        vq.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"});
        vq.push_back('{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, "divu_by0"});
        vq.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf"});
        vq.push_back('{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2"});
        vq.push_back('{OP_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, "div_m9by0"});
        vq.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"});
        vq.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu_2p32"});
        vq.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, "divu_by1"});
        foreach (vq[i]) run_op(vq[i].op, vq[i].a, vq[i].b, vq[i].hi, vq[i].lo, vq[i].name);

        // MFHI one cycle after DIVU 10/3 starts.
        @(negedge clk);
        op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd10; rt_val = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        mf_req = 1'b1;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("mf stall_cycles", 64'(n), 64'd33);
        chk("mf done_at_release", 64'(done), 64'd1);
        chk("mf hi", 64'(hi), 64'd1);
        chk("mf lo", 64'(lo), 64'd3);
        mf_req = 1'b0;

        // MTLO issued while MULTU 6*7 is busy.
        @(negedge clk);
        op_valid = 1'b1; op = OP_MULTU; rs_val = 32'd6; rt_val = 32'd7;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op = OP_MTLO; rs_val = 32'hCAFE_F00D;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            if (n == 16) chk("mtlo_busy lo_hold", 64'(lo), 64'd3);
            @(negedge clk);
            #1;
        end
        chk("mtlo_busy stall_cycles", 64'(n), 64'd33);
        chk("mtlo_busy lo_product", 64'(lo), 64'd42);
        chk("mtlo_busy hi_product", 64'(hi), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("mtlo_busy lo_written", 64'(lo), 64'hCAFE_F00D);
        chk("mtlo_busy no_done", 64'(done), 64'd0);
        chk("mtlo_busy idle", 64'(busy), 64'd0);

        // Reset in the middle of CALC.
        @(negedge clk);
        op_valid = 1'b1; op = OP_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("postreset done", 64'(done), 64'd0);
        run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu_6x7");

        for (int i = 0; i < 24; i++) begin
            rc = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15)) ^ {32{ra[0]}};
                2: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            ref_model(rc, ra, rb, rh, rl);
            run_op(rc, ra, rb, rh, rl, $sformatf("rand%0d_op%0d", i, rc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_seq.md
Name: hilo_muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI and LO architectural registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the decode/execute stage and runs multiply/divide over multiple cycles (shift-add multiply, restoring divide).
- Drives a stall to the pipeline while a later HI/LO access or new command would conflict.
- Sits beside the ALU and is fed by the main decoder's HI/LO-class instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  command present this cycle.
- op  in  3  command: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others reserved, ignored.
- rs_val  in  WIDTH  operand A (multiplicand / dividend / MT source).
- rt_val  in  WIDTH  operand B (multiplier / divisor).
- mf_req  in  1  MFHI/MFLO in execute this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  multi-cycle operation in progress.
- stall  out  1  freeze upstream pipeline; combinational = busy & (op_valid | mf_req).
- done  out  1  one-cycle pulse when HI/LO are written by a mul/div.

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIXUP.
- IDLE + op_valid + MT op: write HI (MTHI) or LO (MTLO) from rs_val at that clock edge. Visible next cycle. Stay IDLE. No done pulse.
- IDLE + op_valid + mul/div op: latch |rs|, |rt| (magnitudes for signed ops, raw values for unsigned) and result signs, clear the accumulator, counter=0, go to CALC. busy=1 from the next cycle.
- CALC: one iteration per cycle; counter increments. After iteration WIDTH-1 (counter wraps 31->0), go to FIXUP.
- MULT/MULTU CALC step: 64-bit shift-add; product = unsigned magnitude product.
- DIV/DIVU CALC step: restoring; quotient and remainder are unsigned.
- FIXUP:
  - Signed MULT: negate the 64-bit product if the operand signs differ.
  - Signed DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write HI/LO (mult: HI=product[63:32], LO=product[31:0]; div: HI=remainder, LO=quotient).
  - Pulse done, return to IDLE; busy drops the same edge.
- Latency: command accepted at edge T -> HI/LO valid and done=1 in the cycle after edge T+WIDTH+1 (34 cycles for WIDTH=32). busy is high for exactly WIDTH+1 cycles.
- hi/lo hold their old values throughout CALC/FIXUP. They are never partially updated.
- Divide by zero: completes with normal latency. LO=all-ones, HI=rs_val, for both DIV and DIVU. No exception.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- While busy: op_valid or mf_req raises stall the same cycle. Commands are not accepted. The requester holds op/operands stable until stall falls.
- Issue is allowed in the cycle after done: that cycle is IDLE, so a command or mf_req there is accepted/served.
- mf_req while IDLE: no stall; hi/lo are read directly.
- op_valid and mf_req together while IDLE: no stall. The MF reads the pre-update hi/lo.
- Reserved op codes: no state change, no stall beyond the busy rule.
- reset_n asserted mid-CALC: immediate abort, all registers to reset values. No done pulse.

Decomposition:
- Shared package `hilo_pkg`:
  - op encoding localparams (OP_MULT..OP_MTLO).
  - state enum (IDLE/CALC/FIXUP).
  - constants WIDTH=32, CNT_W=5.
- One natural sub-module, `muldiv_step`: combinational single-iteration datapath (shift-add or restoring subtract selected by an is_div input). The sequencer instantiates it once and owns all registers, counter, FSM and sign fix-up.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulses once, busy high 33 cycles.
- MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=100; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 while idle -> hi=0x12345678 next cycle, no stall, no done; MTLO issued while busy -> stall=1 until busy falls, then lo is written.
- MFHI (mf_req=1) issued 1 cycle after DIVU 10/3 starts -> stall held ~33 cycles, released the cycle after done, with HI=1 and LO=3 then visible.
- reset_n pulsed low at CALC counter=15 -> hi=lo=0, busy=0, no done; a subsequent MULTU 6*7 gives LO=42, HI=0.
